// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer.
// The bank mask is computed at a fixed wide width; callers cast it down to the bank size.
package tail_light_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } mode_t;

  localparam int MAX_BANK = 32;

  // The step counter must be able to hold the value N itself, not just N-1.
  function automatic int step_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Returns a mask with the k innermost lamps of a bank set.
  // Bit 0 is the innermost lamp.
  function automatic logic [MAX_BANK-1:0] bank_fill(input int k);
    if (k <= 0) begin
      return '0;
    end
    if (k >= MAX_BANK) begin
      return '1;
    end
    return (MAX_BANK'(1) << k) - MAX_BANK'(1);
  endfunction

endpackage

// File: rtl/tail_light_seq_if.sv
// Driver-request and lamp-drive bundle between the debounce logic and the sequencer.
interface tail_light_seq_if #(parameter int N_PER_SIDE = 3);
  logic                    left;
  logic                    right;
  logic                    hazards;
  logic                    brake;
  logic [2*N_PER_SIDE-1:0] lights;

  modport master (output left, right, hazards, brake, input lights);
  modport slave  (input left, right, hazards, brake, output lights);
endinterface

// File: rtl/step_tick_gen.sv
// Animation-rate divider: emits a one-cycle tick every STEP_DIV clocks.
// Counting restarts from zero on reset, so the first tick is STEP_DIV cycles after release.
module step_tick_gen #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == CW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/tail_light_seq.sv
// Tail-light sequencer: sequential turn animation, hazard flash and brake overlay
// for two banks of N_PER_SIDE lamps, stepping at the rate set by step_tick_gen.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int N_PER_SIDE = 3,
  parameter int STEP_DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  tail_light_seq_if.slave  bus
);

  localparam int N  = N_PER_SIDE;
  localparam int SW = step_width(N_PER_SIDE);

  mode_t           mode_reg;
  mode_t           mode_next;
  logic [SW-1:0]   step_reg;
  logic [SW-1:0]   step_next;
  logic [2*N-1:0]  lights_reg;
  logic [2*N-1:0]  lights_next;
  logic            tick;
  logic            haz_req;
  logic [N-1:0]    full_mask;
  logic [N-1:0]    left_fill;
  logic [N-1:0]    right_gap;

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign haz_req = bus.hazards | (bus.left & bus.right);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg   <= IDLE;
      step_reg   <= '0;
      lights_reg <= '0;
    end else begin
      mode_reg   <= mode_next;
      step_reg   <= step_next;
      lights_reg <= lights_next;
    end
  end

  // Turn sequences only start from IDLE, which forces the all-off gap between repeats.
  always_comb begin
    mode_next = mode_reg;
    step_next = step_reg;
    if (tick) begin
      unique case (mode_reg)
        IDLE: begin
          if (haz_req) begin
            mode_next = HAZ;
            step_next = '0;
          end else if (bus.left) begin
            mode_next = LEFT;
            step_next = SW'(1);
          end else if (bus.right) begin
            mode_next = RIGHT;
            step_next = SW'(1);
          end
        end
        LEFT, RIGHT: begin
          if (haz_req) begin
            mode_next = HAZ;
            step_next = '0;
          end else if (step_reg < SW'(N)) begin
            step_next = step_reg + SW'(1);
          end else begin
            mode_next = IDLE;
            step_next = '0;
          end
        end
        HAZ: begin
          mode_next = IDLE;
          step_next = '0;
        end
        default: begin
          mode_next = IDLE;
          step_next = '0;
        end
      endcase
    end
  end

  // Decode from the next state so the registered lamps line up with the state register.
  always_comb begin
    full_mask   = N'(bank_fill(N));
    left_fill   = N'(bank_fill(int'(step_next)));
    right_gap   = N'(bank_fill(N - int'(step_next)));
    lights_next = '0;
    unique case (mode_next)
      IDLE: begin
        if (bus.brake) begin
          lights_next = '1;
        end
      end
      LEFT: begin
        lights_next[2*N-1:N] = left_fill;
        if (bus.brake) begin
          lights_next[N-1:0] = full_mask;
        end
      end
      RIGHT: begin
        // The right bank's innermost lamp is its MSB, so fill from the top down.
        lights_next[N-1:0] = full_mask & ~right_gap;
        if (bus.brake) begin
          lights_next[2*N-1:N] = full_mask;
        end
      end
      HAZ: begin
        lights_next = '1;
      end
      default: begin
        lights_next = '0;
      end
    endcase
  end

  assign bus.lights = lights_reg;

endmodule
